// File: rtl/gamma_seq_if.sv
// gamma_seq_if: handshake and state bus for the Gamma byte-serial sequencer.
//   in_valid/in_ready/in_state    : upstream state hand-off (into the sequencer)
//   out_valid/out_ready/out_state : substituted state hand-off (out of the sequencer)
// Modports:
//   master : the environment side (feeds states, consumes results)
//   slave  : the sequencer side
interface gamma_seq_if #(
  parameter int unsigned NBYTES = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   in_state;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   out_state;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/gamma_seq.sv
// gamma_seq: byte-serial Gamma (S-box) layer sequencer.
// Accepts an 8*NBYTES-bit state, pushes each byte (byte 0 = MSB first) through
// one shared external combinational S-box over NBYTES cycles, then presents
// the substituted state until downstream takes it.
// Ports:
//   i_clk    : rising-edge clock
//   i_rst    : asynchronous active-high reset
//   bus      : gamma_seq_if.slave (in_valid/in_ready/in_state, out_valid/out_ready/out_state)
//   o_sb_in  : byte presented to the shared S-box (0 outside RUN)
//   i_sb_out : S-box result for o_sb_in, same cycle
//   o_busy   : high while substituting
module gamma_seq #(
  parameter int unsigned NBYTES = 16,
  parameter int unsigned CW     = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  gamma_seq_if.slave    bus,
  output logic [7:0]    o_sb_in,
  input  logic [7:0]    i_sb_out,
  output logic          o_busy
);

  localparam int unsigned W = 8 * NBYTES;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  logic [1:0]    r_st,  w_st_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [W-1:0]  r_buf, w_buf_nxt;
  logic [7:0]    w_cur_byte;

  // Byte cnt of the buffer, byte 0 sitting in the MSBs.
  always_comb begin
    w_cur_byte = 8'h00;
    for (int k = 0; k < int'(NBYTES); k++) begin
      if (r_cnt == CW'(k)) begin
        w_cur_byte = r_buf[W-1-8*k -: 8];
      end
    end
  end

  always_comb begin
    w_st_nxt  = r_st;
    w_cnt_nxt = r_cnt;
    w_buf_nxt = r_buf;
    case (r_st)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_buf_nxt = bus.in_state;
          w_cnt_nxt = '0;
          w_st_nxt  = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int k = 0; k < int'(NBYTES); k++) begin
          if (r_cnt == CW'(k)) begin
            w_buf_nxt[W-1-8*k -: 8] = i_sb_out;
          end
        end
        if (r_cnt == LAST) begin
          w_cnt_nxt = '0;
          w_st_nxt  = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_st_nxt = ST_IDLE;
        end
      end
      default: begin
        // Unreachable encoding: recover to IDLE.
        w_st_nxt  = ST_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_st  <= ST_IDLE;
      r_cnt <= '0;
      r_buf <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_cnt <= w_cnt_nxt;
      r_buf <= w_buf_nxt;
    end
  end

  // All outputs decode from registers only; no valid->ready paths.
  assign bus.in_ready  = (r_st == ST_IDLE);
  assign bus.out_valid = (r_st == ST_DONE);
  assign bus.out_state = r_buf;
  assign o_busy        = (r_st == ST_RUN);
  assign o_sb_in       = (r_st == ST_RUN) ? w_cur_byte : 8'h00;

endmodule

// File: tb/tb_gamma_seq.sv
// tb_gamma_seq: directed self-checking bench for gamma_seq with a partial
// involutive byte S-box model covering the bytes these vectors touch.
module tb_gamma_seq;

  localparam int unsigned NB = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  sb_in;
  logic [7:0]  sb_out;
  logic        busy;
  int          n_cmp;
  int          n_fail;
  int          cyc;

  gamma_seq_if #(.NBYTES(NB)) bus ();

  gamma_seq #(.NBYTES(NB), .CW(4)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .bus      (bus.slave),
    .o_sb_in  (sb_in),
    .i_sb_out (sb_out),
    .o_busy   (busy)
  );

  localparam logic [127:0] ORD  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SORD = 128'ha7d3e671d0ac4d793ac991fc1e4754bd;
  localparam logic [127:0] SZ   = {16{8'ha7}};

  // Involutive pairs 0x00..0x0f <-> SORD bytes; anything else gets an
  // arbitrary (non-involutive) image that these vectors never reach.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [127:0] lo;
    logic [127:0] hi;
    logic [7:0]   r;
    lo = ORD;
    hi = SORD;
    r  = x ^ 8'h5a;
    for (int k = 0; k < 16; k++) begin
      if (x == lo[127-8*k -: 8]) r = hi[127-8*k -: 8];
      if (x == hi[127-8*k -: 8]) r = lo[127-8*k -: 8];
    end
    return r;
  endfunction

  always_comb sb_out = sbox(sb_in);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Accept st, then run until out_valid. lat counts edges from the acceptance
  // edge (inclusive) to the edge after which out_valid is seen.
  task automatic do_run(input logic [127:0] st, input logic iv_during, output int lat,
                        output int nbusy, output logic [127:0] sbseq);
    bus.in_valid = 1'b1;
    bus.in_state = st;
    @(posedge clk); #1;
    bus.in_valid = iv_during;
    bus.in_state = ~st;
    lat   = 1;
    nbusy = 0;
    sbseq = '0;
    while (!bus.out_valid && lat < 40) begin
      if (busy) begin
        nbusy++;
        sbseq = {sbseq[119:0], sb_in};
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.out_ready = 1'b0;
    #12;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (sb_in !== 8'h00) begin n_fail++;
      $display("FAIL reset_sb_in got %h want 00", sb_in); end
    n_cmp++; if (bus.out_state !== 128'h0) begin n_fail++;
      $display("FAIL reset_out_state got %h want 0", bus.out_state); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_all_zero();
    int lat, nb;
    logic [127:0] seq;
    do_run(128'h0, 1'b0, lat, nb, seq);
    n_cmp++; if (lat !== 17) begin n_fail++;
      $display("FAIL zero_latency got %0d want 17", lat); end
    n_cmp++; if (nb !== 16) begin n_fail++;
      $display("FAIL zero_busy_cycles got %0d want 16", nb); end
    n_cmp++; if (bus.out_state !== SZ) begin n_fail++;
      $display("FAIL zero_out_state got %h want %h", bus.out_state, SZ); end
    consume();
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL zero_after_consume got rdy=%b vld=%b want 1/0", bus.in_ready,
               bus.out_valid); end
  endtask

  task automatic test_ordered();
    int lat, nb;
    logic [127:0] seq;
    do_run(ORD, 1'b0, lat, nb, seq);
    n_cmp++; if (bus.out_state !== SORD) begin n_fail++;
      $display("FAIL ord_out_state got %h want %h", bus.out_state, SORD); end
    n_cmp++; if (seq !== ORD) begin n_fail++;
      $display("FAIL ord_sb_in_seq got %h want %h", seq, ORD); end
    n_cmp++; if (lat !== 17) begin n_fail++;
      $display("FAIL ord_latency got %0d want 17", lat); end
    consume();
  endtask

  task automatic test_involution();
    int lat, nb;
    logic [127:0] seq;
    do_run(SORD, 1'b0, lat, nb, seq);
    n_cmp++; if (bus.out_state !== ORD) begin n_fail++;
      $display("FAIL inv_out_state got %h want %h", bus.out_state, ORD); end
    n_cmp++; if (seq !== SORD) begin n_fail++;
      $display("FAIL inv_sb_in_seq got %h want %h", seq, SORD); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat, nb;
    logic [127:0] seq;
    do_run(ORD, 1'b1, lat, nb, seq);
    n_cmp++; if (lat !== 17 || nb !== 16) begin n_fail++;
      $display("FAIL bp_run_with_in_valid got lat=%0d busy=%0d want 17/16", lat, nb); end
    bus.in_valid = 1'b1;
    bus.in_state = 128'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++;
        $display("FAIL bp_hold_%0d got vld=%b rdy=%b want 1/0", i, bus.out_valid,
                 bus.in_ready); end
      n_cmp++; if (bus.out_state !== SORD) begin n_fail++;
        $display("FAIL bp_state_%0d got %h want %h", i, bus.out_state, SORD); end
    end
    // Handshake with in_valid still high: must not be taken in DONE.
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got rdy=%b busy=%b vld=%b want 1/0/0", bus.in_ready, busy,
               bus.out_valid); end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL bp_no_accept got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    int lat, nb;
    logic [127:0] seq;
    bus.in_valid = 1'b1;
    bus.in_state = ORD;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    n_cmp++; if (busy !== 1'b1 || sb_in !== 8'h06) begin n_fail++;
      $display("FAIL mid_run_pre got busy=%b sb_in=%h want 1/06", busy, sb_in); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || bus.out_valid !== 1'b0 || sb_in !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_run_rst got busy=%b vld=%b sb_in=%h want 0/0/00", busy,
               bus.out_valid, sb_in); end
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_state !== 128'h0) begin n_fail++;
      $display("FAIL mid_run_rst_state got rdy=%b st=%h want 1/0", bus.in_ready,
               bus.out_state); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_run(128'h0, 1'b0, lat, nb, seq);
    n_cmp++; if (lat !== 17 || bus.out_state !== SZ) begin n_fail++;
      $display("FAIL mid_run_after got lat=%0d st=%h want 17/%h", lat, bus.out_state, SZ);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int t1, t2, guard;
    logic [127:0] r1, r2;
    r1 = 'x;
    r2 = 'x;
    t1 = 0;
    t2 = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_state  = 128'h0;
    @(posedge clk); #1;
    t1 = cyc;
    bus.in_state = ORD;
    guard = 0;
    while (!bus.in_ready && guard < 40) begin
      if (bus.out_valid) r1 = bus.out_state;
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    t2 = cyc;
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (bus.out_valid) r2 = bus.out_state;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_cmp++; if (t2 - t1 !== 18) begin n_fail++;
      $display("FAIL b2b_spacing got %0d want 18", t2 - t1); end
    n_cmp++; if (r1 !== SZ) begin n_fail++;
      $display("FAIL b2b_first got %h want %h", r1, SZ); end
    n_cmp++; if (r2 !== SORD) begin n_fail++;
      $display("FAIL b2b_second got %h want %h", r2, SORD); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_all_zero();
    test_ordered();
    test_involution();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gamma_seq.md
# gamma_seq

Byte-serial sequencer for the Gamma (nonlinear substitution) layer of the cipher round. It accepts a 128-bit state, organised as 16 bytes of a 4x4 byte matrix, and drives each byte in turn through a single shared 8-bit combinational S-box over 16 cycles. It then presents the substituted 128-bit state downstream. The S-box instance sits outside this block and is wired to the `sb_in`/`sb_out` ports, so one S-box serves the whole state.

## Interface
- `NBYTES`, default 16: number of bytes per state; the state width is `8*NBYTES`.
- `CW`, default 4: width of the byte counter; must satisfy `2**CW >= NBYTES`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream has a state on `in_state`.
- `in_ready`  out  1  block can accept a state.
- `in_state`  in  `8*NBYTES`  input state; byte k = `in_state[8*(NBYTES-k)-1 -: 8]` (byte 0 = MSB).
- `out_valid`  out  1  `out_state` holds a completed result.
- `out_ready`  in  1  downstream accepts the result.
- `out_state`  out  `8*NBYTES`  substituted state, same byte ordering as `in_state`.
- `sb_in`  out  8  byte presented to the shared S-box.
- `sb_out`  in  8  S-box result for `sb_in`, combinational, same cycle.
- `busy`  out  1  high while in RUN.

## Operation
- Internal registers: state register `st`, counter `cnt[CW-1:0]`, byte buffer `buf[8*NBYTES-1:0]`.
- `st` has three states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`: `buf <= in_state`, `cnt <= 0`, go to RUN.
- RUN:
  - `sb_in` = `buf` byte `cnt`.
  - At each edge: byte `cnt` of `buf` <= `sb_out`, all other bytes hold, `cnt <= cnt+1`.
  - When `cnt == NBYTES-1`, the final byte is written, `cnt` returns to 0 and `st` goes to DONE.
  - `in_valid` is ignored in RUN.
- DONE:
  - `out_valid` = 1 and `out_state` = `buf`.
  - On `out_valid && out_ready`: go to IDLE.
  - `buf` holds until the next acceptance.
- Output decode:
  - `in_ready` = (`st` == IDLE).
  - `out_valid` = (`st` == DONE).
  - `busy` = (`st` == RUN).
  - `sb_in` = 8'h00 outside RUN.
- `out_state` is driven from `buf` at all times. Its value is meaningful only while `out_valid` is high.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.
- `in_state` is sampled only on the acceptance edge; later changes to it have no effect.
- Counter arithmetic is unsigned and `CW` bits wide. `cnt` never exceeds `NBYTES-1`.

## Timing
- Reset (`rst` = 1, asynchronous, effective immediately):
  - `st` = IDLE, `cnt` = 0, `buf` = 0.
  - Outputs: `in_ready` = 1, `out_valid` = 0, `busy` = 0, `sb_in` = 0, `out_state` = 0.
- Reset mid-RUN or mid-DONE: any partial or unconsumed result is discarded and no `out_valid` pulse is produced. The first edge after `rst` deasserts may accept a new state.
- Latency:
  - Acceptance edge at cycle T.
  - RUN occupies cycles T+1 .. T+NBYTES.
  - `out_valid` rises after edge T+NBYTES, i.e. NBYTES+1 edges after acceptance.
- Throughput with `out_ready` held high: one state per NBYTES+2 cycles (1 IDLE, NBYTES RUN, 1 DONE).
- Backpressure: DONE holds indefinitely while `out_ready` = 0, with `out_state` stable.
- When `out_valid && out_ready` occurs, `in_ready` rises in the next cycle. A simultaneous `in_valid` in DONE is not accepted.
- `sb_out` must settle within the same cycle as `sb_in`. The block registers it at the edge that ends that cycle.

## Test plan
- All-zero state: `in_state` = 128'h0 with the team byte S-box attached.
  - `out_state` = {16{8'ha7}}.
  - `out_valid` rises exactly 17 edges after acceptance.
  - `busy` is high for exactly 16 cycles.
- Ordered bytes: `in_state` = 128'h000102030405060708090a0b0c0d0e0f.
  - `out_state` = 128'ha7d3e671d0ac4d793ac991fc1e4754bd.
  - `sb_in` sequence observed in RUN is 00,01,...,0f.
- Involution round-trip: feed the previous result back as a new input.
  - `out_state` = 128'h000102030405060708090a0b0c0d0e0f.
- Backpressure: hold `out_ready` = 0 for 5 cycles after `out_valid` rises.
  - `out_valid` and `out_state` stay stable and `in_ready` stays 0.
  - `in_valid` pulsed during RUN and DONE is ignored.
- Reset mid-run: assert `rst` asynchronously during RUN cycle 7, not on a clock edge.
  - `busy`, `out_valid` and `sb_in` go to 0 immediately; `in_ready` goes to 1 and `out_state` goes to 0.
  - A following state 128'h0 yields {16{8'ha7}} with normal latency.
- Back-to-back: two states with `out_ready` held at 1.
  - Second acceptance occurs exactly 18 cycles after the first.
  - Both results are correct.
